axis_matrix_source: RTL and testbench

- AXI-stream transmitter (master) that feeds matrix rows into the systolic array's AXI-stream input port.
- Holds a small row store of ROWS entries, each N*DATA_WIDTH bits, loaded through a simple write port by the test harness or host.
- On start, streams rows 0..num_rows-1 as one frame, one row per beat, with tlast on the final beat.
- Fully honours tready backpressure.

---
 rtl/axis_matrix_source.sv | 120 ++++++++++++
 tb/tb_axis_matrix_source.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_matrix_source.sv
`default_nettype none
// axis_matrix_source: small row store plus an AXI-stream master that plays rows 0..K-1 as one frame.
// The store is loaded through the write port while idle; frames fully honour tready backpressure.
module axis_matrix_source #(
  parameter  int N          = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int ROWS       = 4,
  localparam int AW         = $clog2(ROWS),
  localparam int W          = N * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic          wr_err,
  input  logic          start,
  input  logic [AW:0]   num_rows,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [AW:0] ROWS_K = (AW+1)'(ROWS);
  localparam logic [AW:0] ONE_K  = (AW+1)'(1);

  state_t       state_q;
  logic [W-1:0] mem_q [ROWS];
  logic [AW:0]  cnt_q;
  logic [AW:0]  k_q;
  logic [W-1:0] tdata_q;
  logic         tvalid_q;
  logic         tlast_q;
  logic         done_q;
  logic         wr_err_q;

  logic [AW:0]  k_d;
  logic [W-1:0] row0_d;
  logic         wr_ok;
  logic         hs;

  assign wr_ok = wr_en && (state_q == IDLE);
  assign hs    = tvalid_q && m_tready;

  always_comb begin
    k_d = num_rows;
    if ((num_rows == '0) || (num_rows > ROWS_K)) begin
      k_d = ROWS_K;
    end
  end

  // Forward a same-cycle write to row 0 so a start coincident with it streams the new contents.
  assign row0_d = (wr_ok && (wr_addr == '0)) ? wr_data : mem_q[0];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= wr_en && (state_q == STREAM);
      case (state_q)
        IDLE: begin
          if (start) begin
            k_q      <= k_d;
            tdata_q  <= row0_d;
            tvalid_q <= 1'b1;
            tlast_q  <= (k_d == ONE_K);
            cnt_q    <= ONE_K;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end else begin
              tdata_q <= mem_q[cnt_q[AW-1:0]];
              cnt_q   <= cnt_q + ONE_K;
              tlast_q <= (cnt_q == (k_q - ONE_K));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == STREAM);
  assign done     = done_q;
  assign wr_err   = wr_err_q;
  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_matrix_source.sv
`default_nettype none
// tb_axis_matrix_source: scenario tasks drive the source and compare each frame
// against a row-store model and the frame-length rule.
module tb_axis_matrix_source;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int ROWS = 4;
  localparam int AW   = 2;
  localparam int W    = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_err;
  logic          start;
  logic [AW:0]   num_rows;
  logic          busy;
  logic          done;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;

  axis_matrix_source #(.N(N), .DATA_WIDTH(DW), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] model_rows [ROWS];
  logic [W-1:0] got_data [$];
  bit           got_last [$];
  bit           pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  int stall_bad, busy_cnt, done_early, werr_cnt;
  bit timeout, done_now, tvalid_after, busy_after;

  function automatic int eff_k(input int n);
    return ((n == 0) || (n > ROWS)) ? ROWS : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Only called while the source is idle, so the write always lands.
  task automatic write_row(input int addr, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = data;
    tick();
    wr_en = 1'b0;
    model_rows[addr] = data;
  endtask

  // rmode: 0 = tready always 1, 1 = fixed toggle pattern, 2 = random.
  task automatic stream_frame(input int k_req, input int rmode, input bit skip_start,
                              input int mid_start_step, input int wr_step);
    int step;
    bit rdy, prev_stall, last_hs, fin;
    logic [W-1:0] prev_data;
    bit prev_last;
    got_data.delete();
    got_last.delete();
    stall_bad = 0; busy_cnt = 0; done_early = 0; werr_cnt = 0;
    timeout = 0; step = 0; prev_stall = 0; fin = 0; prev_data = '0; prev_last = 0;
    if (!skip_start) begin
      start    = 1'b1;
      num_rows = k_req[AW:0];
      tick();
      start = 1'b0;
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (busy) busy_cnt++;
      if (done) done_early++;
      if (wr_err) werr_cnt++;
      if (m_tvalid) begin
        if (prev_stall && ((m_tdata !== prev_data) || (m_tlast !== prev_last))) stall_bad++;
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = pat[step % 7];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        m_tready = rdy;
        start    = (step == mid_start_step);
        if (step == wr_step) begin
          wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hDEADBEEF;
        end else begin
          wr_en = 1'b0;
        end
        if (rdy) begin
          got_data.push_back(m_tdata);
          got_last.push_back(m_tlast);
          prev_stall = 0;
        end else begin
          prev_stall = 1; prev_data = m_tdata; prev_last = m_tlast;
        end
        last_hs = rdy && m_tlast;
        step++;
      end else begin
        m_tready = 1'($urandom_range(0, 1));
        start = 1'b0; wr_en = 1'b0; last_hs = 0;
      end
      tick();
      if (last_hs) begin
        fin = 1;
        break;
      end
    end
    timeout  = !fin;
    start    = 1'b0;
    wr_en    = 1'b0;
    m_tready = 1'b0;
    if (wr_err) werr_cnt++;
    done_now     = done;
    tvalid_after = m_tvalid;
    busy_after   = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; num_rows = '0; m_tready = 0;
    repeat (3) tick();
    checks++;
    if ({m_tvalid, m_tlast, busy, done, wr_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got {tvalid,tlast,busy,done,wr_err}=%b, expected 00000",
               {m_tvalid, m_tlast, busy, done, wr_err});
    end
    checks++;
    if (m_tdata !== '0) begin
      errors++; $display("FAIL reset_tdata: got %h, expected 0", m_tdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int k;
    write_row(0, 32'h04030201); write_row(1, 32'h08070605);
    write_row(2, 32'h0C0B0A09); write_row(3, 32'h100F0E0D);
    k = eff_k(4);
    stream_frame(4, 0, 0, -1, -1);
    checks++;
    if (timeout || got_data.size() != k) begin
      errors++; $display("FAIL basic_count: got %0d beats (timeout=%0b), expected %0d", got_data.size(), timeout, k);
    end
    for (int i = 0; i < got_data.size() && i < k; i++) begin
      checks++;
      if (got_data[i] !== model_rows[i] || got_last[i] !== (i == k - 1)) begin
        errors++; $display("FAIL basic_beat%0d: got %h last=%0b, expected %h last=%0b",
                           i, got_data[i], got_last[i], model_rows[i], (i == k - 1));
      end
    end
    checks++;
    if (busy_cnt != 4 || done_early != 0) begin
      errors++; $display("FAIL basic_busy: busy cycles=%0d early done=%0d, expected 4 and 0", busy_cnt, done_early);
    end
    checks++;
    if ({done_now, tvalid_after, busy_after} !== 3'b100) begin
      errors++; $display("FAIL basic_done: got {done,tvalid,busy}=%b, expected 100", {done_now, tvalid_after, busy_after});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_width: done=%0b one cycle later, expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    stream_frame(4, 1, 0, -1, -1);
    checks++;
    if (timeout || got_data.size() != 4 || stall_bad != 0) begin
      errors++; $display("FAIL bp_frame: beats=%0d stall violations=%0d timeout=%0b, expected 4, 0, 0",
                         got_data.size(), stall_bad, timeout);
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if (got_data[i] !== model_rows[i] || got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL bp_beat%0d: got %h last=%0b, expected %h last=%0b",
                           i, got_data[i], got_last[i], model_rows[i], (i == 3));
      end
    end
    tick();
  endtask

  task automatic test_short_frames();
    int lens [3] = '{1, 0, 6};
    for (int t = 0; t < 3; t++) begin
      int k;
      k = eff_k(lens[t]);
      stream_frame(lens[t], 0, 0, -1, -1);
      checks++;
      if (timeout || got_data.size() != k || done_now !== 1'b1) begin
        errors++; $display("FAIL len%0d_count: beats=%0d done=%0b, expected %0d beats and done", lens[t], got_data.size(), done_now, k);
      end
      for (int i = 0; i < got_data.size() && i < k; i++) begin
        checks++;
        if (got_data[i] !== model_rows[i] || got_last[i] !== (i == k - 1)) begin
          errors++; $display("FAIL len%0d_beat%0d: got %h last=%0b, expected %h last=%0b",
                             lens[t], i, got_data[i], got_last[i], model_rows[i], (i == k - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_write_busy();
    stream_frame(4, 0, 0, -1, 1);
    checks++;
    if (werr_cnt != 1) begin
      errors++; $display("FAIL busy_write_err: wr_err cycles=%0d, expected 1", werr_cnt);
    end
    checks++;
    if (got_data.size() != 4 || got_data[2] !== model_rows[2]) begin
      errors++; $display("FAIL busy_write_row2: beats=%0d row2=%h, expected 4 and %h",
                         got_data.size(), (got_data.size() > 2) ? got_data[2] : '0, model_rows[2]);
    end
    tick();
    write_row(2, 32'hDEADBEEF);
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL idle_write_err: wr_err=%0b, expected 0", wr_err);
    end
    stream_frame(4, 0, 0, -1, -1);
    checks++;
    if (got_data.size() != 4 || got_data[2] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL idle_write_row2: beats=%0d row2=%h, expected 4 and deadbeef",
                         got_data.size(), (got_data.size() > 2) ? got_data[2] : '0);
    end
    tick();
  endtask

  task automatic test_mid_start();
    int extra;
    stream_frame(4, 0, 0, 1, -1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_tvalid) extra++;
      tick();
    end
    checks++;
    if (got_data.size() != 4 || extra != 0) begin
      errors++; $display("FAIL mid_start: beats=%0d extra valid cycles=%0d, expected 4 and 0", got_data.size(), extra);
    end
  endtask

  task automatic test_back_to_back();
    stream_frame(2, 0, 0, -1, -1);
    start = 1'b1; num_rows = 3'd3;
    tick();
    start = 1'b0;
    checks++;
    if (done_now !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== model_rows[0]) begin
      errors++; $display("FAIL b2b_first: done=%0b then tvalid=%0b tdata=%h, expected 1, 1, %h",
                         done_now, m_tvalid, m_tdata, model_rows[0]);
    end
    stream_frame(3, 0, 1, -1, -1);
    checks++;
    if (timeout || got_data.size() != 3 || got_data[2] !== model_rows[2] || got_last[2] !== 1'b1) begin
      errors++; $display("FAIL b2b_frame: beats=%0d, expected 3 ending with %h last", got_data.size(), model_rows[2]);
    end
    tick();
  endtask

  task automatic test_start_write();
    start = 1'b1; num_rows = 3'd1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hA5A55A5A;
    tick();
    start = 1'b0; wr_en = 1'b0;
    model_rows[0] = 32'hA5A55A5A;
    checks++;
    if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || m_tdata !== 32'hA5A55A5A) begin
      errors++; $display("FAIL start_write: tvalid=%0b tlast=%0b tdata=%h, expected 1, 1, a5a55a5a", m_tvalid, m_tlast, m_tdata);
    end
    stream_frame(1, 0, 1, -1, -1);
    tick();
  endtask

  task automatic test_reset_midframe();
    start = 1'b1; num_rows = 3'd4;
    tick();
    start = 1'b0; m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tick();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== model_rows[1]) begin
      errors++; $display("FAIL stall_beat2: tvalid=%0b tdata=%h, expected 1 and %h", m_tvalid, m_tdata, model_rows[1]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({m_tvalid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL mid_reset: got {tvalid,busy,done}=%b, expected 000", {m_tvalid, busy, done});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_done: done=%0b after reset, expected 0", done);
    end
    stream_frame(4, 0, 0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== model_rows[i]) begin
        errors++; $display("FAIL post_reset_beat%0d: got %h, expected %h",
                           i, (i < got_data.size()) ? got_data[i] : '0, model_rows[i]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n, k;
      for (int r = 0; r < ROWS; r++) write_row(r, $urandom);
      n = $urandom_range(0, 7);
      k = eff_k(n);
      stream_frame(n, 2, 0, -1, -1);
      checks++;
      if (timeout || got_data.size() != k || stall_bad != 0 || done_now !== 1'b1) begin
        errors++; $display("FAIL rand%0d_frame: n=%0d beats=%0d stalls_bad=%0d done=%0b, expected %0d beats, 0, 1",
                           it, n, got_data.size(), stall_bad, done_now, k);
      end
      for (int i = 0; i < got_data.size() && i < k; i++) begin
        checks++;
        if (got_data[i] !== model_rows[i] || got_last[i] !== (i == k - 1)) begin
          errors++; $display("FAIL rand%0d_beat%0d: got %h last=%0b, expected %h last=%0b",
                             it, i, got_data[i], got_last[i], model_rows[i], (i == k - 1));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frames();
    test_write_busy();
    test_mid_start();
    test_back_to_back();
    test_start_write();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
